// File: rtl/mul_pkg.sv
// Shared types for the 16-bit repeated-addition multiplier.
// State encoding and datapath width used by control and datapath.
package mul_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    MULT   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mul_ctrl.sv
// Control FSM for the repeated-addition multiplier.
// Loads A then B over a shared bus, iterates P += A until B is zero.
module mul_ctrl
  import mul_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic op_valid,
  output logic op_ready,
  input  logic eqz,
  output logic LdA,
  output logic LdB,
  output logic LdP,
  output logic clrP,
  output logic decB,
  output logic busy,
  output logic res_valid,
  input  logic res_ready
);

  state_t state;
  state_t nxt;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state and strobes; operand loads follow op_valid in the same cycle.
  always_comb begin
    nxt       = state;
    op_ready  = 1'b0;
    LdA       = 1'b0;
    LdB       = 1'b0;
    LdP       = 1'b0;
    clrP      = 1'b0;
    decB      = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          nxt = LOAD_A;
        end
      end
      LOAD_A: begin
        if (abort) begin
          nxt  = IDLE;
          clrP = 1'b1;
        end else begin
          op_ready = 1'b1;
          LdA      = op_valid;
          if (op_valid) begin
            nxt = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (abort) begin
          nxt  = IDLE;
          clrP = 1'b1;
        end else begin
          op_ready = 1'b1;
          LdB      = op_valid;
          clrP     = op_valid;
          if (op_valid) begin
            nxt = MULT;
          end
        end
      end
      MULT: begin
        if (abort) begin
          nxt  = IDLE;
          clrP = 1'b1;
        end else if (eqz) begin
          nxt = DONE;
        end else begin
          LdP  = 1'b1;
          decB = 1'b1;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (abort) begin
          nxt  = IDLE;
          clrP = 1'b1;
        end else if (res_ready) begin
          nxt = IDLE;
        end
      end
      default: begin
        nxt  = IDLE;
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl with a behavioural datapath fixture.
// Products and cycle counts are predicted from plain arithmetic.
module tb_mul_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, op_valid, eqz, res_ready;
  logic op_ready, LdA, LdB, LdP, clrP, decB, busy, res_valid;

  logic [15:0] data_in;
  logic [15:0] ra, rb, rp;

  int n_cmp = 0;
  int n_err = 0;

  mul_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready), .eqz(eqz),
    .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Datapath fixture driven by the controller strobes.
  always @(posedge clk) begin
    if (LdA) ra <= data_in;
    if (LdB) rb <= data_in;
    else if (decB) rb <= rb - 16'd1;
    if (clrP) rp <= 16'd0;
    else if (LdP) rp <= rp + ra;
  end

  assign eqz = (rb == 16'd0);

  function automatic logic [7:0] outs();
    return {op_ready, LdA, LdB, LdP, clrP, decB, busy, res_valid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete multiplication with optional stalls.
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input int wait_a, input int hold);
    int mc;
    int lp;
    logic [15:0] prod;
    prod = 16'((32'(a) * 32'(b)) & 32'hFFFF);
    @(negedge clk);
    start = 1'b1;
    #1 chk("idle_busy", 32'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b0;
    for (int i = 0; i < wait_a; i++) begin
      #1 chk("wait_a", 32'(outs()), 32'h82);
      @(negedge clk);
    end
    op_valid = 1'b1;
    data_in = a;
    #1 chk("load_a", 32'(outs()), 32'hC2);
    @(negedge clk);
    data_in = b;
    #1 chk("load_b", 32'(outs()), 32'hAA);
    @(negedge clk);
    op_valid = 1'b0;
    data_in = $urandom();
    mc = 0;
    lp = 0;
    #1;
    while (!res_valid && mc < 1000) begin
      if (LdP !== decB || clrP !== 1'b0 || op_ready !== 1'b0)
        chk("mult_strobes", 32'(outs()), {24'd0, 8'h16});
      mc++;
      if (LdP) lp++;
      @(negedge clk);
      #1;
    end
    chk("mult_cycles", mc, 32'(b) + 1);
    chk("ldp_count", lp, 32'(b));
    chk("done_outs", 32'(outs()), 32'h03);
    chk("product", 32'(rp), 32'(prod));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1 chk("hold_outs", 32'(outs()), 32'h03);
      chk("hold_p", 32'(rp), 32'(prod));
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1 chk("ready_outs", 32'(outs()), 32'h03);
    @(negedge clk);
    res_ready = 1'b0;
    #1 chk("back_idle", 32'(outs()), 32'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    op_valid = 1'b0;
    res_ready = 1'b0;
    data_in = 16'd0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", 32'(outs()), 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("post_reset", 32'(outs()), 0);
    abort = 1'b1;
    @(negedge clk);
    #1 chk("idle_abort", 32'(outs()), 0);
    abort = 1'b0;

    run(16'd5, 16'd3, 0, 0);
    run(16'd7, 16'd0, 0, 0);
    run(16'hFFFF, 16'd2, 0, 5);
    run(16'd11, 16'd4, 10, 0);

    // Abort on the second MULT cycle, with start raised alongside.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1;
    data_in = 16'd4;
    @(negedge clk);
    data_in = 16'd9;
    @(negedge clk);
    op_valid = 1'b0;
    #1 chk("abort_m1", 32'(outs()), 32'h16);
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    #1 chk("abort_outs", 32'(outs()), 32'h0A);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    #1 chk("abort_idle", 32'(outs()), 0);
    chk("abort_p", 32'(rp), 0);
    @(negedge clk);
    #1 chk("abort_nostart", 32'(busy), 0);

    // Reset dropped mid-MULT.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1;
    data_in = 16'd6;
    @(negedge clk);
    data_in = 16'd8;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    #1 chk("pre_rst_mult", 32'(outs()), 32'h16);
    rst_n = 1'b0;
    #1 chk("rst_mid", 32'(outs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("rst_release", 32'(outs()), 0);
    run(16'd3, 16'd3, 0, 0);

    for (int k = 0; k < 6; k++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom());
      b = 16'($urandom_range(0, 20));
      run(a, b, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Control-path FSM for the 16-bit repeated-addition multiplier datapath.
- Accepts a start request, then sequences operand A and operand B from the shared data_in bus using a valid/ready handshake.
- Drives LdA/LdB/LdP/clrP/decB and watches eqz to iterate P += A until B reaches zero.
- Holds the product with a result valid/ready handshake; supports synchronous abort.

Parameters:
- none. All widths are fixed by the 16-bit datapath; state encodings come from the package.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new multiplication; sampled only in IDLE
- abort  in  1  synchronous cancel; valid in any non-IDLE state
- op_valid  in  1  data_in carries a valid operand this cycle
- op_ready  out  1  controller accepts an operand this cycle
- eqz  in  1  datapath B counter == 0 (combinational from B register)
- LdA  out  1  load A register from data_in
- LdB  out  1  load B counter from data_in
- LdP  out  1  load P register with A+P
- clrP  out  1  clear P register
- decB  out  1  decrement B counter
- busy  out  1  state != IDLE
- res_valid  out  1  P holds the final product
- res_ready  in  1  consumer has taken the product

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, MULT, DONE.
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - Every output reads 0 while in reset and after release: op_ready, LdA, LdB, LdP, clrP, decB, busy, res_valid.
  - Reset mid-operation abandons the operation; datapath register contents are don't-care.
- IDLE:
  - start=1 -> LOAD_A at the next edge; otherwise stay.
  - All strobes 0.
- LOAD_A:
  - op_ready=1.
  - LdA = op_valid (Mealy, same cycle), so data_in is captured at that edge.
  - op_valid=1 -> LOAD_B; else wait indefinitely.
- LOAD_B:
  - op_ready=1.
  - LdB = clrP = op_valid, so B is loaded and P cleared at the same edge.
  - op_valid=1 -> MULT.
- MULT:
  - eqz=0: LdP=1 and decB=1 in the same cycle; stay in MULT.
  - eqz=1: LdP=0, decB=0; go to DONE.
  - Takes exactly B+1 cycles in MULT. B=0 gives 1 cycle and P=0.
- DONE:
  - res_valid=1, all strobes 0, so P is held stable.
  - res_ready=1 -> IDLE at the next edge; res_valid is 0 in IDLE.
  - Until res_ready=1, res_valid stays asserted and the state holds.
- Arithmetic:
  - Product = (A*B) mod 2^16; overflow silently wraps in the datapath adder.
  - The controller does no arithmetic.
- Abort:
  - Priority over every other transition in LOAD_A, LOAD_B, MULT and DONE.
  - Next state is IDLE; clrP=1 that cycle; all other strobes and op_ready forced to 0.
  - Abort in IDLE is ignored.
- start outside IDLE is ignored; it is not queued.
- busy is 1 in LOAD_A, LOAD_B, MULT and DONE.
- Mutual exclusion: at most one of LdA or LdB is high in any cycle; LdP and clrP are never high together.

Decomposition:
- Package mul_pkg holds:
  - The state encoding localparams: IDLE=0, LOAD_A=1, LOAD_B=2, MULT=3, DONE=4, 3-bit.
  - The DATA_W=16 constant shared with the datapath.
- No sub-modules: one state register plus a combinational next-state/output block.
- A top-level mul_top instantiates mul_ctrl and the datapath; it is out of scope here.

Test Plan:
- Reset then start, A=5, B=3 (op_valid asserted in LOAD_A and LOAD_B) -> LdA and LdB each pulse once; LdP/decB high for 3 cycles; 4 cycles spent in MULT; res_valid rises; P=15.
- A=7, B=0 -> MULT lasts 1 cycle with no LdP; res_valid asserted; P=0.
- A=0xFFFF, B=2 -> P=0xFFFE (wrap); res_valid held 5 cycles with res_ready=0 while P stays stable; IDLE on the first cycle res_ready=1.
- op_valid withheld 10 cycles in LOAD_A -> op_ready=1 throughout, no LdA, state holds; proceeds normally once op_valid=1.
- abort asserted on the 2nd MULT cycle of A=4, B=9 -> clrP=1 that cycle; IDLE next; busy=0; a start asserted in the same cycle as abort is ignored.
- rst_n dropped mid-MULT -> all outputs 0 immediately; IDLE after release; a subsequent A=3, B=3 run gives P=9.
